// File: rtl/song_sequencer_pkg.sv
// Shared piano constants: note codes, melody entry layout and sequencer state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package song_sequencer_pkg;

    // Note codes stored in the melody ROM; 1..8 walk the white keys C4..C5
    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D4   = 4'd2;
    localparam logic [3:0] NOTE_E4   = 4'd3;
    localparam logic [3:0] NOTE_F4   = 4'd4;
    localparam logic [3:0] NOTE_G4   = 4'd5;
    localparam logic [3:0] NOTE_A4   = 4'd6;
    localparam logic [3:0] NOTE_B4   = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;
    localparam logic [3:0] NOTE_END  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_t;

    // One ROM word: note code in the high nibble, duration in ticks in the low nibble
    typedef struct packed {
        logic [3:0] code;
        logic [3:0] dur;
    } rom_entry_t;

    // Piano key vector for a note code: C4 drives bit 7, C5 drives bit 0, anything else is silent
    function automatic logic [7:0] note_onehot(input logic [3:0] code);
        logic [7:0] keys;
        keys = 8'h00;
        if (code >= NOTE_C4 && code <= NOTE_C5) begin
            keys = 8'h80 >> (code - NOTE_C4);
        end
        return keys;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Melody storage: combinational address -> {code, dur} lookup.
// Latency: 0 cycles (pure combinational read).
// Backpressure: none; data is valid whenever addr is.
module song_rom
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    // Short phrase: C4 for two ticks, one tick of rest, C5 for one tick, then end of song
    always_comb begin
        data = {NOTE_END, 4'd0};
        case (int'(addr))
            0:       data = {NOTE_C4,   4'd2};
            1:       data = {NOTE_REST, 4'd1};
            2:       data = {NOTE_C5,   4'd0};
            default: data = {NOTE_END,  4'd0};
        endcase
    end

endmodule

// File: rtl/song_sequencer.sv
// Plays the melody ROM onto the piano key vector, with live-key override and optional looping.
// Latency: first note reaches sw_out two cycles after the play pulse (one FETCH cycle in between).
// Backpressure: none; live keys pause note/gap timing in place instead of dropping it.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int TICK_DIV   = 12_500_000,
    parameter int GAP_CYCLES = 1_000_000,
    parameter int SONG_LEN   = 16,
    localparam int ADDR_W    = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [7:0]        live_sw,
    output logic [7:0]        sw_out,
    output logic              busy,
    output logic [ADDR_W-1:0] step,
    output logic              done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] STEP_LAST = ADDR_W'(SONG_LEN - 1);

    seq_state_t        state_q;
    logic [ADDR_W-1:0] step_q;
    logic [3:0]        code_q;
    logic [3:0]        dur_q;
    logic [TICK_W-1:0] tick_q;
    logic [3:0]        dcnt_q;
    logic [GAP_W-1:0]  gap_q;
    logic              done_q;
    logic              busy_q;

    logic [7:0]        rom_dat;
    rom_entry_t        entry;
    logic              live_act;
    logic              end_loop;
    logic [3:0]        dur_last;

    song_rom #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .addr (step_q),
        .data (rom_dat)
    );

    assign entry    = rom_entry_t'(rom_dat);
    assign live_act = |live_sw;
    // At end of song, loop only if the song actually has content before END
    assign end_loop = loop_en && (step_q != '0);
    // Duration 0 plays as a single tick
    assign dur_last = (dur_q == 4'd0) ? 4'd0 : dur_q - 4'd1;

    // Sequencer FSM: fetch/hold/gap walk through the ROM, live keys freeze all timing
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            code_q  <= NOTE_REST;
            dur_q   <= 4'd0;
            tick_q  <= '0;
            dcnt_q  <= 4'd0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                step_q  <= '0;
                code_q  <= NOTE_REST;
                tick_q  <= '0;
                dcnt_q  <= 4'd0;
                gap_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (play) begin
                            step_q  <= '0;
                            state_q <= ST_FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        code_q <= entry.code;
                        dur_q  <= entry.dur;
                        tick_q <= '0;
                        dcnt_q <= 4'd0;
                        gap_q  <= '0;
                        if (entry.code == NOTE_END) begin
                            step_q <= '0;
                            if (end_loop) begin
                                state_q <= ST_FETCH;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!live_act) begin
                            if (tick_q == TICK_LAST) begin
                                tick_q <= '0;
                                if (dcnt_q == dur_last) begin
                                    dcnt_q  <= 4'd0;
                                    state_q <= ST_GAP;
                                end else begin
                                    dcnt_q <= dcnt_q + 4'd1;
                                end
                            end else begin
                                tick_q <= tick_q + 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (!live_act) begin
                            if (gap_q == GAP_LAST) begin
                                gap_q <= '0;
                                if (step_q == STEP_LAST) begin
                                    step_q <= '0;
                                    if (end_loop) begin
                                        state_q <= ST_FETCH;
                                    end else begin
                                        state_q <= ST_IDLE;
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                    end
                                end else begin
                                    step_q  <= step_q + 1'b1;
                                    state_q <= ST_FETCH;
                                end
                            end else begin
                                gap_q <= gap_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Key vector: live keys pass straight through when idle or when they override playback
    always_comb begin
        sw_out = 8'h00;
        case (state_q)
            ST_IDLE:  sw_out = live_sw;
            ST_HOLD:  sw_out = live_act ? live_sw : note_onehot(code_q);
            ST_GAP:   sw_out = live_act ? live_sw : 8'h00;
            default:  sw_out = 8'h00;
        endcase
    end

    assign busy = busy_q;
    assign step = step_q;
    assign done = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: per-cycle expected outputs queued alongside stimulus, checked by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_song_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       play = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] live_sw = 8'h00;
    logic [7:0] sw_out;
    logic       busy;
    logic [1:0] step;
    logic       done;

    always #5 CLK = ~CLK;

    song_sequencer #(
        .TICK_DIV   (4),
        .GAP_CYCLES (2),
        .SONG_LEN   (4)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .play    (play),
        .stop    (stop),
        .loop_en (loop_en),
        .live_sw (live_sw),
        .sw_out  (sw_out),
        .busy    (busy),
        .step    (step),
        .done    (done)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [11:0] sb[$];
    string       phase = "reset";

    // Staged stimulus, applied just after the next rising edge; pulses self-clear
    logic       s_rst  = 1'b0;
    logic       s_play = 1'b0;
    logic       s_stop = 1'b0;
    logic       s_loop = 1'b0;
    logic [7:0] s_live = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (sw,busy,done,step packed)", tag, got, exp);
        end
    endtask

    // Drive n cycles of the staged stimulus and queue the outputs expected in each cycle
    task automatic cyc(input logic [7:0] e_sw, input logic e_busy, input logic e_done,
                       input logic [1:0] e_step, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            RESET   = s_rst;
            play    = s_play;
            stop    = s_stop;
            loop_en = s_loop;
            live_sw = s_live;
            sb.push_back({e_sw, e_busy, e_done, e_step});
            s_rst  = 1'b0;
            s_play = 1'b0;
            s_stop = 1'b0;
        end
    endtask

    task automatic rst_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            RESET = 1'b1;
            play  = 1'b0;
            stop  = 1'b0;
        end
    endtask

    // Play pulse in IDLE, then the single FETCH cycle
    task automatic play_head();
        s_play = 1'b1;
        cyc(8'h00, 1'b0, 1'b0, 2'd0, 1);
        cyc(8'h00, 1'b1, 1'b0, 2'd0, 1);
    endtask

    // From the gap after C4 up to and including FETCH of the END entry
    task automatic song_tail();
        cyc(8'h00, 1'b1, 1'b0, 2'd0, 2);   // gap after C4
        cyc(8'h00, 1'b1, 1'b0, 2'd1, 7);   // fetch + 4-cycle rest + gap
        cyc(8'h00, 1'b1, 1'b0, 2'd2, 1);   // fetch C5
        cyc(8'h01, 1'b1, 1'b0, 2'd2, 4);   // C5, dur 0 plays as one tick
        cyc(8'h00, 1'b1, 1'b0, 2'd2, 2);   // gap
        cyc(8'h00, 1'b1, 1'b0, 2'd3, 1);   // fetch END
    endtask

    task automatic song_end();
        cyc(8'h00, 1'b0, 1'b1, 2'd0, 1);   // done pulse, already idle
        cyc(8'h00, 1'b0, 1'b0, 2'd0, 1);
    endtask

    task automatic full_song(input logic replay);
        play_head();
        if (replay) begin
            cyc(8'h80, 1'b1, 1'b0, 2'd0, 4);
            s_play = 1'b1;
            cyc(8'h80, 1'b1, 1'b0, 2'd0, 4);
        end else begin
            cyc(8'h80, 1'b1, 1'b0, 2'd0, 8);
        end
        song_tail();
        song_end();
    endtask

    // Monitor: compare each cycle's outputs against the queued expectation
    initial begin : monitor
        logic [11:0] e;
        forever begin
            @(posedge CLK);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check(phase, {20'd0, sw_out, busy, done, step}, {20'd0, e});
            end
        end
    end

    initial begin
        rst_cyc(3);

        phase = "reset_state";
        s_live = 8'h24;
        cyc(8'h24, 1'b0, 1'b0, 2'd0, 1);
        s_live = 8'h00;
        cyc(8'h00, 1'b0, 1'b0, 2'd0, 1);

        phase = "basic_song";
        full_song(1'b0);

        phase = "replay_ignored";
        full_song(1'b1);

        // Live keys from HOLD cycle index 3 (fourth cycle) of C4 for 5 cycles
        phase = "live_override";
        play_head();
        cyc(8'h80, 1'b1, 1'b0, 2'd0, 3);
        s_live = 8'h10;
        cyc(8'h10, 1'b1, 1'b0, 2'd0, 5);
        s_live = 8'h00;
        cyc(8'h80, 1'b1, 1'b0, 2'd0, 5);
        song_tail();
        song_end();

        phase = "loop";
        s_loop = 1'b1;
        play_head();
        cyc(8'h80, 1'b1, 1'b0, 2'd0, 8);
        song_tail();
        cyc(8'h00, 1'b1, 1'b0, 2'd0, 1);   // refetch index 0, no done
        cyc(8'h80, 1'b1, 1'b0, 2'd0, 2);
        s_stop = 1'b1;
        cyc(8'h80, 1'b1, 1'b0, 2'd0, 1);
        cyc(8'h00, 1'b0, 1'b0, 2'd0, 2);
        s_loop = 1'b0;

        phase = "play_stop";
        play_head();
        cyc(8'h80, 1'b1, 1'b0, 2'd0, 2);
        s_play = 1'b1;
        s_stop = 1'b1;
        cyc(8'h80, 1'b1, 1'b0, 2'd0, 1);
        s_live = 8'h42;
        cyc(8'h42, 1'b0, 1'b0, 2'd0, 1);
        s_play = 1'b1;
        s_stop = 1'b1;
        cyc(8'h42, 1'b0, 1'b0, 2'd0, 1);
        cyc(8'h42, 1'b0, 1'b0, 2'd0, 1);
        s_live = 8'h00;
        cyc(8'h00, 1'b0, 1'b0, 2'd0, 1);

        phase = "reset_in_gap";
        play_head();
        cyc(8'h80, 1'b1, 1'b0, 2'd0, 8);
        cyc(8'h00, 1'b1, 1'b0, 2'd0, 2);
        cyc(8'h00, 1'b1, 1'b0, 2'd1, 6);   // fetch + rest + first gap cycle
        s_rst = 1'b1;
        cyc(8'h00, 1'b1, 1'b0, 2'd1, 1);   // second gap cycle, reset sampled at its end
        cyc(8'h00, 1'b0, 1'b0, 2'd0, 2);

        phase = "restart";
        full_song(1'b0);

        @(posedge CLK);
        @(posedge CLK);
        #3;
        phase = "sb_drain";
        check(phase, sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
